mole_game_fsm: RTL and testbench

Game controller for the switch-whack game. It consumes the debounced switches, the LFSR random nibble and the countdown's game-over flag. It produces the mole LED pattern, the running score and the countdown reset. It sits between the input conditioning (debouncer, lfsr) and the display path (countdown, clock_display).

---
 rtl/mole_game_fsm.sv | 158 +++++++++++++++
 tb/tb_mole_game_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_fsm.sv
// mole_game_fsm: game controller for the switch-whack game.
// Spawns moles on the LED bank from the LFSR nibble, scores switch flips
// against lit moles, and sequences IDLE -> ARM -> PLAY -> DONE.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             debounced start button (level, edge-detected here)
//   game_over         countdown expiry flag from the 1 Hz domain
//   switches          debounced switch levels, one per mole
//   random            LFSR nibble; low bits pick the spawn position
//   lfsr_en           LFSR shift enable
//   rst_game          countdown reset request (level)
//   leds              lit moles
//   points            saturating score, 0..MAX_POINTS
//   state             IDLE=0, ARM=1, PLAY=2, DONE=3
module mole_game_fsm #(
  parameter int unsigned NUM_MOLES   = 8,
  parameter int unsigned SPAWN_TICKS = 50000000,
  parameter int unsigned ARM_TICKS   = 110000000,
  parameter int unsigned MAX_POINTS  = 99
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 game_over,
  input  logic [NUM_MOLES-1:0] switches,
  input  logic [3:0]           random,
  output logic                 lfsr_en,
  output logic                 rst_game,
  output logic [NUM_MOLES-1:0] leds,
  output logic [10:0]          points,
  output logic [1:0]           state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned IDX_W   = $clog2(NUM_MOLES);
  localparam int unsigned POP_W   = $clog2(NUM_MOLES + 1);
  localparam int unsigned SPAWN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam int unsigned ARM_W   = (ARM_TICKS > 1) ? $clog2(ARM_TICKS) : 1;
  localparam int unsigned SCORE_W = 12;

  logic [SPAWN_W-1:0]   spawn_cnt, spawn_cnt_d;
  logic [ARM_W-1:0]     arm_cnt, arm_cnt_d;
  logic [NUM_MOLES-1:0] sw_last;
  logic                 start_last;
  logic                 go_q;
  logic [1:0]           state_d;
  logic [NUM_MOLES-1:0] leds_d;
  logic [10:0]          points_d;

  logic                      start_edge;
  logic [NUM_MOLES-1:0]      chg, hits, misses, spawn_mask;
  logic                      spawn_wrap;
  logic [POP_W-1:0]          hit_cnt, miss_cnt;
  logic signed [SCORE_W-1:0] score_sum;
  logic [10:0]               score_clamped;

  // Flip detection, spawn decode and clamped score update
  always_comb begin
    start_edge = start & ~start_last;
    chg        = switches ^ sw_last;
    hits       = chg & leds;
    misses     = chg & ~leds;
    hit_cnt    = POP_W'($countones(hits));
    miss_cnt   = POP_W'($countones(misses));
    spawn_wrap = (spawn_cnt == SPAWN_W'(SPAWN_TICKS - 1));
    spawn_mask = NUM_MOLES'(1) << random[IDX_W-1:0];
    score_sum  = $signed(SCORE_W'(points)) + $signed(SCORE_W'(hit_cnt))
               - $signed(SCORE_W'(miss_cnt));
    if (score_sum < 12'sd0)
      score_clamped = '0;
    else if (score_sum > $signed(SCORE_W'(MAX_POINTS)))
      score_clamped = 11'(MAX_POINTS);
    else
      score_clamped = 11'(score_sum);
  end

  // Next-state and datapath next values
  always_comb begin
    state_d     = state;
    leds_d      = leds;
    points_d    = points;
    spawn_cnt_d = spawn_cnt;
    arm_cnt_d   = arm_cnt;
    case (state)
      IDLE: begin
        leds_d = '0;
        if (start_edge) begin
          state_d   = ARM;
          points_d  = '0;
          arm_cnt_d = '0;
        end
      end
      ARM: begin
        leds_d = '0;
        if (arm_cnt == ARM_W'(ARM_TICKS - 1)) begin
          state_d     = PLAY;
          spawn_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt + ARM_W'(1);
        end
      end
      PLAY: begin
        spawn_cnt_d = spawn_wrap ? '0 : spawn_cnt + SPAWN_W'(1);
        // Hits are masked with the pre-spawn LEDs so a coincident hit wins
        leds_d   = (leds | (spawn_wrap ? spawn_mask : '0)) & ~hits;
        points_d = score_clamped;
        if (go_q) begin
          state_d = DONE;
          leds_d  = '0;
        end
      end
      DONE: begin
        leds_d = '0;
        if (start_edge) begin
          state_d   = ARM;
          points_d  = '0;
          arm_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        leds_d  = '0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      leds       <= '0;
      points     <= '0;
      spawn_cnt  <= '0;
      arm_cnt    <= '0;
      sw_last    <= '0;
      start_last <= 1'b1;
      go_q       <= 1'b0;
      lfsr_en    <= 1'b0;
      rst_game   <= 1'b1;
    end else begin
      state      <= state_d;
      leds       <= leds_d;
      points     <= points_d;
      spawn_cnt  <= spawn_cnt_d;
      arm_cnt    <= arm_cnt_d;
      sw_last    <= switches;
      start_last <= start;
      go_q       <= game_over;
      lfsr_en    <= (state_d != DONE);
      rst_game   <= (state_d == IDLE) || (state_d == ARM);
    end
  end

endmodule

// File: tb/tb_mole_game_fsm.sv
// Directed self-checking bench for mole_game_fsm with
// NUM_MOLES=8, SPAWN_TICKS=4, ARM_TICKS=3, MAX_POINTS=99.
module tb_mole_game_fsm;

  logic        clk;
  logic        rst;
  logic        start;
  logic        game_over;
  logic [7:0]  switches;
  logic [3:0]  random;
  logic        lfsr_en;
  logic        rst_game;
  logic [7:0]  leds;
  logic [10:0] points;
  logic [1:0]  state;

  int checks;
  int errors;
  int t;
  int exp_pts;

  mole_game_fsm #(
    .NUM_MOLES  (8),
    .SPAWN_TICKS(4),
    .ARM_TICKS  (3),
    .MAX_POINTS (99)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .game_over(game_over),
    .switches (switches),
    .random   (random),
    .lfsr_en  (lfsr_en),
    .rst_game (rst_game),
    .leds     (leds),
    .points   (points),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until the next spawn edge (every 4th cycle after PLAY entry)
  task automatic run_to_spawn(input logic [3:0] idx);
    random = idx;
    do step(); while (t % 4 != 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    t         = 0;
    rst       = 1'b0;
    start     = 1'b1;
    game_over = 1'b0;
    switches  = 8'h00;
    random    = 4'hB;
    #1 rst = 1'b1;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_points", 32'(points), 32'd0);
    chk("rst_rst_game", 32'(rst_game), 32'd1);
    chk("rst_lfsr_en", 32'(lfsr_en), 32'd0);
    step(); step();
    rst = 1'b0;

    // Start held through reset must not start a game
    step(); step(); step();
    chk("held_start_state", 32'(state), 32'd0);
    chk("held_start_rst_game", 32'(rst_game), 32'd1);
    chk("idle_lfsr_en", 32'(lfsr_en), 32'd1);

    start = 1'b0; step();
    start = 1'b1; step();
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_rst_game", 32'(rst_game), 32'd1);
    start = 1'b0;
    step(); step();
    chk("arm_hold_state", 32'(state), 32'd1);
    step();
    chk("play_state", 32'(state), 32'd2);
    chk("play_rst_game", 32'(rst_game), 32'd0);
    t = 0;

    // First spawn four cycles after PLAY entry at idx 3
    step(); step(); step();
    chk("pre_spawn_leds", 32'(leds), 32'h00);
    step();
    chk("spawn_leds", 32'(leds), 32'h08);

    switches = switches ^ 8'h08; step();
    chk("hit_leds", 32'(leds), 32'h00);
    chk("hit_points", 32'(points), 32'd1);

    switches = switches ^ 8'h20; step();
    chk("miss_points", 32'(points), 32'd0);
    switches = switches ^ 8'h20; step();
    chk("floor_points", 32'(points), 32'd0);
    chk("floor_leds", 32'(leds), 32'h00);

    step();
    chk("respawn_leds", 32'(leds), 32'h08);
    run_to_spawn(4'h0);
    run_to_spawn(4'h1);
    run_to_spawn(4'h2);
    chk("multi_spawn_leds", 32'(leds), 32'h0F);

    switches = switches ^ 8'h07; step();
    chk("triple_hit_points", 32'(points), 32'd3);
    chk("triple_hit_leds", 32'(leds), 32'h08);
    switches = switches ^ 8'h68; step();
    chk("mixed_points", 32'(points), 32'd2);
    chk("mixed_leds", 32'(leds), 32'h00);

    // Fill all eight moles and hit them together until saturation
    exp_pts = 2;
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 8; i++) run_to_spawn(4'(i));
      chk("full_leds", 32'(leds), 32'hFF);
      switches = switches ^ 8'hFF; step();
      exp_pts = (exp_pts + 8 > 99) ? 99 : exp_pts + 8;
      chk("round_points", 32'(points), 32'(exp_pts));
    end
    chk("sat_points", 32'(points), 32'd99);

    switches = switches ^ 8'hFF; step();
    chk("eight_miss_points", 32'(points), 32'd91);

    // Spawn and hit on idx 2 in the same cycle
    run_to_spawn(4'h2);
    chk("idx2_leds", 32'(leds), 32'h04);
    step(); step(); step();
    switches = switches ^ 8'h04; step();
    chk("collide_leds", 32'(leds), 32'h00);
    chk("collide_points", 32'(points), 32'd92);

    // game_over reaches DONE two edges later; last PLAY cycle still scores
    random = 4'h5;
    game_over = 1'b1; step();
    chk("go_wait_state", 32'(state), 32'd2);
    switches = switches ^ 8'h01; step();
    chk("done_state", 32'(state), 32'd3);
    chk("done_leds", 32'(leds), 32'h00);
    chk("done_points", 32'(points), 32'd91);
    chk("done_lfsr_en", 32'(lfsr_en), 32'd0);
    chk("done_rst_game", 32'(rst_game), 32'd0);
    switches = switches ^ 8'h18; step(); step();
    chk("frozen_points", 32'(points), 32'd91);
    chk("frozen_state", 32'(state), 32'd3);
    game_over = 1'b0; step();

    start = 1'b1; step();
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_points", 32'(points), 32'd0);
    chk("restart_rst_game", 32'(rst_game), 32'd1);
    start = 1'b0;
    step(); step(); step();
    chk("replay_state", 32'(state), 32'd2);
    t = 0;

    random = 4'h6;
    step(); step(); step(); step();
    chk("replay_spawn_leds", 32'(leds), 32'h40);
    switches = switches ^ 8'h40; step();
    chk("replay_hit_points", 32'(points), 32'd1);
    step(); step(); step();
    chk("replay_respawn_leds", 32'(leds), 32'h40);

    // Asynchronous reset mid-PLAY
    #2 rst = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_leds", 32'(leds), 32'h00);
    chk("async_points", 32'(points), 32'd0);
    chk("async_rst_game", 32'(rst_game), 32'd1);
    chk("async_lfsr_en", 32'(lfsr_en), 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
